// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the sram-like req/addr_ok/data_ok protocol.
// Used by both the memory responder and the cache miss ports.
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // One accepted request as it sits in the pending queue.
  typedef struct packed {
    logic        wr;
    logic [3:0]  be;
    logic [29:0] waddr;
    logic [31:0] wdata;
  } req_entry_t;

  // Low address bits below the access size are ignored, so misaligned
  // accesses snap down to their natural lane.
  function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: return 4'b0001 << a;
      SIZE_HALF: return 4'b0011 << {a[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_responder_if.sv
// Request/response bundle of the sram-like protocol.
interface sram_like_if;
  logic        hold;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;

  modport master (output hold, req, wr, size, addr, wdata,
                  input  addr_ok, rdata, data_ok);
  modport slave  (input  hold, req, wr, size, addr, wdata,
                  output addr_ok, rdata, data_ok);
endinterface

// File: rtl/sram_like_responder_resp_queue.sv
// In-order pending-request FIFO; each slot carries an age counter that
// saturates at LATENCY so the head knows when its response is due.
module resp_queue
  import sram_like_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  req_entry_t push_entry,
  input  logic       pop,
  output req_entry_t head_entry,
  output logic       head_valid,
  output logic       head_ready,
  output logic       full
);

  localparam int PW  = $clog2(DEPTH);
  localparam int AGW = $clog2(LATENCY + 1);
  localparam logic [AGW-1:0] AGE_SAT  = AGW'(LATENCY);
  localparam logic [AGW-1:0] AGE_RDY  = AGW'(LATENCY - 1);
  localparam logic [PW:0]    CNT_FULL = (PW + 1)'(DEPTH);

  req_entry_t [DEPTH-1:0]          slot_q, slot_d;
  logic       [DEPTH-1:0][AGW-1:0] age_q, age_d;
  logic       [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic       [PW:0]               count_q, count_d;
  logic                            do_push, do_pop;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == CNT_FULL);
  assign head_entry = slot_q[rptr_q];
  assign head_ready = head_valid && (age_q[rptr_q] >= AGE_RDY);
  assign do_push    = push && !full;
  assign do_pop     = pop && head_ready;

  always_comb begin
    slot_d  = slot_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Empty slots age too; harmless because a push restarts them at 0.
    for (int i = 0; i < DEPTH; i++)
      age_d[i] = (age_q[i] == AGE_SAT) ? age_q[i] : age_q[i] + 1'b1;
    if (do_push) begin
      slot_d[wptr_q] = push_entry;
      age_d[wptr_q]  = '0;
      wptr_d         = wptr_q + 1'b1;
    end
    if (do_pop)
      rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      age_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      age_q   <= age_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// Memory-side sram-like responder: queued in-order requests backed by a
// word array, each answered LATENCY edges after acceptance (or later).
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  sram_like_if.slave  bus
);

  req_entry_t            push_entry, head;
  logic                  push, pop, full, head_valid, head_ready;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem_q [2**ADDR_WIDTH];
  logic                  data_ok_q, data_ok_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  unused_bits;

  // Acceptance depends only on state and hold, never on req.
  assign bus.addr_ok = rst && !bus.hold && !full;
  assign push        = bus.req && bus.addr_ok;
  assign push_entry  = '{wr:    bus.wr,
                         be:    size_to_be(bus.size, bus.addr[1:0]),
                         waddr: bus.addr[31:2],
                         wdata: bus.wdata};

  resp_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head),
    .head_valid (head_valid),
    .head_ready (head_ready),
    .full       (full)
  );

  assign pop = head_ready;
  // Upper word-address bits alias onto the array.
  assign idx = head.waddr[ADDR_WIDTH-1:0];
  assign unused_bits = ^{head_valid, head.waddr[29:ADDR_WIDTH]};

  // Memory is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (pop && head.wr) begin
      for (int b = 0; b < 4; b++)
        if (head.be[b]) mem_q[idx][8*b +: 8] <= head.wdata[8*b +: 8];
    end
  end

  always_comb begin
    data_ok_d = pop;
    rdata_d   = rdata_q;
    if (pop)
      rdata_d = head.wr ? 32'h0 : mem_q[idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed + randomized bench for sram_like_responder with a queue-based
// reference model of acceptance, response timing and memory contents.
module tb_sram_like_responder;
  import sram_like_pkg::*;

  localparam int AW  = 10;
  localparam int QD  = 4;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  sram_like_if bus();

  sram_like_responder #(
    .ADDR_WIDTH  (AW),
    .QUEUE_DEPTH (QD),
    .LATENCY     (LAT)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          r;
    bit          wr;
    bit [3:0]    be;
    int          idx;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [int];
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] obs_rd;
  int          obs_cyc;
  int          acc_cyc;
  bit          acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte lanes touched by an access: size bytes starting at the address
  // rounded down to the access size.
  function automatic bit [3:0] lanes(input logic [1:0] size, input logic [31:0] a);
    int n, off;
    bit [3:0] m;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = (int'(a[1:0]) / n) * n;
    m = '0;
    for (int i = 0; i < n; i++) m[off + i] = 1'b1;
    return m;
  endfunction

  task automatic set_in(input bit req, input bit wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    bus.req = req; bus.wr = wr; bus.size = size;
    bus.addr = addr; bus.wdata = wdata; bus.hold = hold;
  endtask

  // One clock: check addr_ok before the edge, responses after it.
  task automatic tick();
    exp_t e, n;
    bit   aok_exp;
    #1;
    aok_exp = rst_n && !bus.hold && (q.size() < QD);
    chk("addr_ok", {31'b0, bus.addr_ok}, {31'b0, aok_exp});
    acc     = bus.req && bus.addr_ok;
    n.wr    = bus.wr;
    n.be    = lanes(bus.size, bus.addr);
    n.idx   = int'(bus.addr[AW+1:2]);
    n.wdata = bus.wdata;
    @(posedge clk);
    #1;
    if (q.size() > 0 && q[0].r == cyc) begin
      chk("data_ok", {31'b0, bus.data_ok}, 32'd1);
      e = q.pop_front();
      if (e.wr) begin
        if (!mmem.exists(e.idx)) mmem[e.idx] = 'x;
        for (int b = 0; b < 4; b++)
          if (e.be[b]) mmem[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
        chk("rdata_wr", bus.rdata, 32'h0);
      end else if (mmem.exists(e.idx) && !$isunknown(mmem[e.idx])) begin
        chk("rdata_rd", bus.rdata, mmem[e.idx]);
      end
      obs_rd  = bus.rdata;
      obs_cyc = cyc;
    end else begin
      chk("data_ok_idle", {31'b0, bus.data_ok}, 32'd0);
    end
    if (acc) begin
      n.r = cyc + LAT;
      if (q.size() > 0 && q[$].r + 1 > n.r) n.r = q[$].r + 1;
      q.push_back(n);
      acc_cyc = cyc;
    end
  endtask

  task automatic txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, output int ka);
    set_in(1'b1, wr, size, addr, wdata, 1'b0);
    acc = 1'b0;
    for (int g = 0; g < 20 && !acc; g++) tick();
    chk("txn_accept", {31'b0, acc}, 32'd1);
    ka = acc_cyc;
    bus.req = 1'b0;
  endtask

  task automatic drain();
    bus.req = 1'b0;
    bus.hold = 1'b0;
    for (int g = 0; g < 100 && q.size() > 0; g++) tick();
    chk("drain_empty", q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data_ok", {31'b0, bus.data_ok}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_addr_ok", {31'b0, bus.addr_ok}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_ok_hold", {31'b0, bus.data_ok}, 32'd0);
    chk("rst_addr_ok_hold", {31'b0, bus.addr_ok}, 32'd0);
    q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, cnt;
    logic [31:0] a;
    set_in(1'b1, 1'b0, SIZE_WORD, 32'h0, 32'h0, 1'b0);
    do_reset();

    // Scenario 1: word write then read back.
    txn(1'b1, SIZE_WORD, 32'h100, 32'hDEADBEEF, k);
    txn(1'b0, SIZE_WORD, 32'h100, 32'h0, k);
    drain();
    chk("s1_rdata", obs_rd, 32'hDEADBEEF);
    chk("s1_latency", obs_cyc - k, LAT);

    // Scenario 2: byte and halfword merges.
    txn(1'b1, SIZE_WORD, 32'h20, 32'h11223344, k);
    txn(1'b1, SIZE_BYTE, 32'h22, 32'h00AA0000, k);
    txn(1'b0, SIZE_WORD, 32'h20, 32'h0, k);
    drain();
    chk("s2_byte", obs_rd, 32'h11AA3344);
    txn(1'b1, SIZE_HALF, 32'h22, 32'hBEEF0000, k);
    txn(1'b0, SIZE_WORD, 32'h20, 32'h0, k);
    drain();
    chk("s2_half", obs_rd, 32'hBEEF3344);

    // Scenario 3: continuous req fills the queue.
    cnt = 0;
    set_in(1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0, 1'b0);
    repeat (8) begin tick(); if (acc) cnt++; end
    bus.req = 1'b0;
    chk("s3_accepts", cnt, 32'd5);
    drain();

    // Scenario 4: hold blocks acceptance only.
    cnt = 0;
    set_in(1'b1, 1'b0, SIZE_WORD, 32'h20, 32'h0, 1'b1);
    repeat (3) begin tick(); if (acc) cnt++; end
    chk("s4_hold_accepts", cnt, 32'd0);
    txn(1'b0, SIZE_WORD, 32'h20, 32'h0, k);
    drain();
    chk("s4_latency", obs_cyc - k, LAT);
    chk("s4_rdata", obs_rd, 32'hBEEF3344);

    // Scenario 5: reset with reads in flight.
    txn(1'b0, SIZE_WORD, 32'h100, 32'h0, k);
    txn(1'b0, SIZE_WORD, 32'h20, 32'h0, k);
    txn(1'b0, SIZE_WORD, 32'h100, 32'h0, k);
    tick();
    do_reset();
    repeat (10) tick();
    txn(1'b0, SIZE_WORD, 32'h100, 32'h0, k);
    drain();
    chk("s5_mem_kept", obs_rd, 32'hDEADBEEF);
    chk("s5_latency", obs_cyc - k, LAT);

    // Scenario 6: upper address bits alias.
    txn(1'b1, SIZE_WORD, 32'h100, 32'hCAFEF00D, k);
    txn(1'b0, SIZE_WORD, 32'h100 + (4 << AW), 32'h0, k);
    drain();
    chk("s6_alias", obs_rd, 32'hCAFEF00D);

    // Randomized traffic over 16 words with random aliasing and hold.
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      a[AW+1:2] = AW'(128 + i);
      txn(1'b1, SIZE_WORD, a, $urandom, k);
    end
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      a[AW+1:2] = AW'(128 + $urandom_range(0, 15));
      set_in($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             a, $urandom, $urandom_range(0, 3) == 0);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
